// File: rtl/spi_register_bank_if.sv
// Register-access bus between the SPI slave front end and the register bank.
// The master drives the address, data and strobes; the slave returns read data.
interface spi_register_bank_if #(
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_DATA_BITS = 8
);
    logic [NUM_ADDR_BITS-1:0] spi_addr;
    logic [NUM_DATA_BITS-1:0] spi_write_data;
    logic                     spi_write_stb;
    logic                     spi_read_stb;
    logic [NUM_DATA_BITS-1:0] spi_read_data;

    modport master (
        output spi_addr,
        output spi_write_data,
        output spi_write_stb,
        output spi_read_stb,
        input  spi_read_data
    );

    modport slave (
        input  spi_addr,
        input  spi_write_data,
        input  spi_write_stb,
        input  spi_read_stb,
        output spi_read_data
    );
endinterface

// File: rtl/spi_register_bank.sv
// SPI-facing register bank: control, status snapshot, sticky events with
// clear-on-read, chip ID and an auto-incrementing 24-bit coefficient write port.
module spi_register_bank #(
    parameter int                     NUM_ADDR_BITS = 7,
    parameter int                     NUM_DATA_BITS = 8,
    parameter logic [NUM_DATA_BITS-1:0] CHIP_ID     = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    spi_register_bank_if.slave         bus,
    output logic [16*NUM_DATA_BITS-1:0] ctrl_regs,
    input  logic [4*NUM_DATA_BITS-1:0]  status_in,
    input  logic [NUM_DATA_BITS-1:0]    event_in,
    output logic [NUM_DATA_BITS-1:0]    event_flags,
    output logic                        irq,
    output logic [NUM_DATA_BITS-1:0]    coef_addr,
    output logic [3*NUM_DATA_BITS-1:0]  coef_data,
    output logic                        coef_wr_stb
);
    localparam int DW = NUM_DATA_BITS;
    localparam int AW = NUM_ADDR_BITS;

    localparam logic [AW-1:0] ADDR_STATUS   = AW'('h10);
    localparam logic [AW-1:0] ADDR_EVENT    = AW'('h14);
    localparam logic [AW-1:0] ADDR_COEF_PTR = AW'('h20);
    localparam logic [AW-1:0] ADDR_COEF_LO  = AW'('h21);
    localparam logic [AW-1:0] ADDR_COEF_MID = AW'('h22);
    localparam logic [AW-1:0] ADDR_COEF_HI  = AW'('h23);
    localparam logic [AW-1:0] ADDR_CHIP_ID  = AW'('h7F);

    logic [DW-1:0]   ctrl_reg [16];
    logic [DW-1:0]   status_byte [4];
    logic [DW-1:0]   read_data_reg;
    logic [DW-1:0]   read_mux;
    logic [DW-1:0]   event_flags_reg;
    logic            irq_reg;
    logic [DW-1:0]   coef_lo_reg;
    logic [DW-1:0]   coef_mid_reg;
    logic [DW-1:0]   coef_addr_reg;
    logic [3*DW-1:0] coef_data_reg;
    logic            coef_wr_stb_reg;

    logic is_ctrl;
    logic is_status;
    logic event_clear;
    logic wr_coef_ptr;
    logic wr_coef_hi;

    assign is_ctrl     = (bus.spi_addr[AW-1:4] == '0);
    assign is_status   = (bus.spi_addr[AW-1:2] == ADDR_STATUS[AW-1:2]);
    assign event_clear = bus.spi_read_stb && (bus.spi_addr == ADDR_EVENT);
    assign wr_coef_ptr = bus.spi_write_stb && (bus.spi_addr == ADDR_COEF_PTR);
    assign wr_coef_hi  = bus.spi_write_stb && (bus.spi_addr == ADDR_COEF_HI);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ctrl
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    ctrl_reg[gi] <= '0;
                end else if (bus.spi_write_stb && is_ctrl && (bus.spi_addr[3:0] == 4'(gi))) begin
                    ctrl_reg[gi] <= bus.spi_write_data;
                end
            end
            assign ctrl_regs[gi*DW +: DW] = ctrl_reg[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_status
            assign status_byte[gi] = status_in[gi*DW +: DW];
        end
    endgenerate

    // Coefficient staging bytes and 0x21-0x23 are write-only and read back as zero.
    always_comb begin
        read_mux = '0;
        if (is_ctrl) begin
            read_mux = ctrl_reg[bus.spi_addr[3:0]];
        end else if (is_status) begin
            read_mux = status_byte[bus.spi_addr[1:0]];
        end else if (bus.spi_addr == ADDR_EVENT) begin
            read_mux = event_flags_reg;
        end else if (bus.spi_addr == ADDR_COEF_PTR) begin
            read_mux = coef_addr_reg;
        end else if (bus.spi_addr == ADDR_CHIP_ID) begin
            read_mux = CHIP_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_data_reg   <= '0;
            event_flags_reg <= '0;
            irq_reg         <= 1'b0;
            coef_lo_reg     <= '0;
            coef_mid_reg    <= '0;
            coef_addr_reg   <= '0;
            coef_data_reg   <= '0;
            coef_wr_stb_reg <= 1'b0;
        end else begin
            if (bus.spi_read_stb) begin
                read_data_reg <= read_mux;
            end
            // New events win over a clear-on-read in the same cycle.
            event_flags_reg <= (event_clear ? '0 : event_flags_reg) | event_in;
            irq_reg         <= |(event_flags_reg & ctrl_reg[15]);

            if (bus.spi_write_stb && (bus.spi_addr == ADDR_COEF_LO)) begin
                coef_lo_reg <= bus.spi_write_data;
            end
            if (bus.spi_write_stb && (bus.spi_addr == ADDR_COEF_MID)) begin
                coef_mid_reg <= bus.spi_write_data;
            end
            coef_wr_stb_reg <= wr_coef_hi;
            if (wr_coef_hi) begin
                coef_data_reg <= {bus.spi_write_data, coef_mid_reg, coef_lo_reg};
            end
            // The pointer advances as the strobe ends; an explicit pointer write overrides it.
            if (wr_coef_ptr) begin
                coef_addr_reg <= bus.spi_write_data;
            end else if (coef_wr_stb_reg) begin
                coef_addr_reg <= coef_addr_reg + 1'b1;
            end
        end
    end

    assign bus.spi_read_data = read_data_reg;
    assign event_flags       = event_flags_reg;
    assign irq               = irq_reg;
    assign coef_addr         = coef_addr_reg;
    assign coef_data         = coef_data_reg;
    assign coef_wr_stb       = coef_wr_stb_reg;
endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank: drives on negedge, samples on the
// following negedge, compares against hand-computed values.
module tb_spi_register_bank;
    logic         clk;
    logic         reset_n;
    logic [127:0] ctrl_regs;
    logic [31:0]  status_in;
    logic [7:0]   event_in;
    logic [7:0]   event_flags;
    logic         irq;
    logic [7:0]   coef_addr;
    logic [23:0]  coef_data;
    logic         coef_wr_stb;

    int checks = 0;
    int errors = 0;

    spi_register_bank_if #(.NUM_ADDR_BITS(7), .NUM_DATA_BITS(8)) bus ();

    spi_register_bank #(
        .NUM_ADDR_BITS(7),
        .NUM_DATA_BITS(8),
        .CHIP_ID      (8'hA5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .ctrl_regs  (ctrl_regs),
        .status_in  (status_in),
        .event_in   (event_in),
        .event_flags(event_flags),
        .irq        (irq),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_wr_stb(coef_wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        bus.spi_addr       = a;
        bus.spi_write_data = d;
        bus.spi_write_stb  = 1'b1;
        @(negedge clk);
        bus.spi_write_stb  = 1'b0;
        $display("write addr %02h data %02h", a, d);
    endtask

    task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
        bus.spi_addr     = a;
        bus.spi_read_stb = 1'b1;
        @(negedge clk);
        bus.spi_read_stb = 1'b0;
        d = bus.spi_read_data;
        $display("read  addr %02h data %02h", a, d);
    endtask

    logic [7:0] rd;

    initial begin
        reset_n            = 1'b0;
        status_in          = '0;
        event_in           = '0;
        bus.spi_addr       = '0;
        bus.spi_write_data = '0;
        bus.spi_write_stb  = 1'b0;
        bus.spi_read_stb   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_read_data", 32'(bus.spi_read_data), 32'h0);
        check("rst_ctrl_zero", 32'(ctrl_regs == '0), 32'h1);
        check("rst_flags", 32'(event_flags), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_coef_addr", 32'(coef_addr), 32'h0);
        check("rst_coef_data", 32'(coef_data), 32'h0);
        check("rst_coef_stb", 32'(coef_wr_stb), 32'h0);

        spi_write(7'h05, 8'h3C);
        check("ctrl5", 32'(ctrl_regs[47:40]), 32'h3C);
        check("ctrl4_untouched", 32'(ctrl_regs[39:32]), 32'h0);
        spi_read(7'h05, rd);
        check("read_ctrl5", 32'(rd), 32'h3C);
        spi_read(7'h7F, rd);
        check("chip_id", 32'(rd), 32'hA5);
        spi_read(7'h30, rd);
        check("unmapped", 32'(rd), 32'h0);

        spi_write(7'h10, 8'hFF);
        status_in = 32'h7700_0042;
        spi_read(7'h10, rd);
        check("status0", 32'(rd), 32'h42);
        spi_read(7'h13, rd);
        check("status3", 32'(rd), 32'h77);
        check("ro_no_ctrl_change", 32'(ctrl_regs == 128'h3C << 40), 32'h1);
        // Read data holds between read strobes.
        @(negedge clk);
        check("read_hold", 32'(bus.spi_read_data), 32'h77);

        event_in = 8'h81;
        @(negedge clk);
        event_in = 8'h00;
        check("flags_set", 32'(event_flags), 32'h81);
        @(negedge clk);
        check("irq_masked", 32'(irq), 32'h0);
        spi_write(7'h0F, 8'h01);
        check("irq_latency", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_on", 32'(irq), 32'h1);
        spi_read(7'h14, rd);
        check("event_read", 32'(rd), 32'h81);
        check("flags_cleared", 32'(event_flags), 32'h0);
        @(negedge clk);
        check("irq_off", 32'(irq), 32'h0);

        event_in = 8'h80;
        @(negedge clk);
        event_in = 8'h00;
        event_in = 8'h01;
        bus.spi_addr     = 7'h14;
        bus.spi_read_stb = 1'b1;
        @(negedge clk);
        bus.spi_read_stb = 1'b0;
        event_in = 8'h00;
        $display("read  addr 14 data %02h (event on clear edge)", bus.spi_read_data);
        check("clr_edge_read", 32'(bus.spi_read_data), 32'h80);
        check("set_wins", 32'(event_flags), 32'h01);

        spi_write(7'h20, 8'hFE);
        spi_read(7'h20, rd);
        check("coef_ptr_read", 32'(rd), 32'hFE);
        spi_write(7'h21, 8'h11);
        spi_write(7'h22, 8'h22);
        check("no_stb_staging", 32'(coef_wr_stb), 32'h0);
        spi_write(7'h23, 8'h33);
        check("c1_stb", 32'(coef_wr_stb), 32'h1);
        check("c1_data", 32'(coef_data), 32'h332211);
        check("c1_addr", 32'(coef_addr), 32'hFE);
        @(negedge clk);
        check("c1_stb_single", 32'(coef_wr_stb), 32'h0);
        check("c1_inc", 32'(coef_addr), 32'hFF);
        spi_write(7'h23, 8'h44);
        check("c2_stb", 32'(coef_wr_stb), 32'h1);
        check("c2_data", 32'(coef_data), 32'h442211);
        check("c2_addr", 32'(coef_addr), 32'hFF);
        @(negedge clk);
        check("c2_wrap", 32'(coef_addr), 32'h00);
        spi_write(7'h23, 8'h55);
        check("c3_addr", 32'(coef_addr), 32'h00);
        check("c3_data", 32'(coef_data), 32'h552211);
        @(negedge clk);
        check("c3_inc", 32'(coef_addr), 32'h01);

        spi_write(7'h23, 8'h66);
        check("c4_addr", 32'(coef_addr), 32'h01);
        spi_write(7'h20, 8'h10);
        check("ptr_override", 32'(coef_addr), 32'h10);
        @(negedge clk);
        check("ptr_hold", 32'(coef_addr), 32'h10);

        spi_write(7'h22, 8'h99);
        reset_n            = 1'b0;
        bus.spi_addr       = 7'h23;
        bus.spi_write_data = 8'h77;
        bus.spi_write_stb  = 1'b1;
        @(negedge clk);
        bus.spi_write_stb  = 1'b0;
        reset_n            = 1'b1;
        $display("write addr 23 data 77 under reset");
        check("rst2_no_stb", 32'(coef_wr_stb), 32'h0);
        check("rst2_coef_data", 32'(coef_data), 32'h0);
        check("rst2_coef_addr", 32'(coef_addr), 32'h0);
        check("rst2_ctrl_zero", 32'(ctrl_regs == '0), 32'h1);
        check("rst2_flags", 32'(event_flags), 32'h0);
        check("rst2_read_data", 32'(bus.spi_read_data), 32'h0);
        @(negedge clk);
        check("rst2_irq", 32'(irq), 32'h0);
        spi_write(7'h23, 8'hAA);
        check("rst2_staging_clear", 32'(coef_data), 32'hAA0000);
        check("rst2_commit_addr", 32'(coef_addr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
